byte_mem_arbiter: RTL and testbench
===================================

# byte_mem_arbiter

Sequencer and arbiter that shares one byte-wide memory port between the processor's instruction-fetch path and its data load/store path. Each 32-bit word access is broken into four single-byte transfers in big-endian order: byte at address A holds bits 31:24. Each transfer delivers one registered 32-bit result with a one-cycle acknowledge. The block sits between the datapath (PC/fetch logic and ALU-address load/store logic) and the 8-bit memory array.

## Interface
Parameters:
- ADDR_W, 5, byte-address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request (read-only), level, held until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_ack  out  1  one-cycle pulse; if_rdata valid from this cycle.
- if_rdata  out  32  fetched word, held until next if_ack.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_ack  out  1  one-cycle pulse; d_rdata valid from this cycle (loads only).
- d_rdata  out  32  loaded word, held until next load d_ack.
- busy  out  1  high in XFER and ACK states.
- mem_addr  out  ADDR_W  byte address to the memory array.
- mem_wdata  out  8  byte write data.
- mem_we  out  1  byte write enable.
- mem_rdata  in  8  combinational (asynchronous) read data for mem_addr.

## Operation
- States:
  - IDLE: if any request is pending, grant it, latch the address, we and wdata, clear cnt, and go to XFER.
  - XFER: cnt counts 0..3. After cnt = 3, go to ACK.
  - ACK: pulse the granted port's ack for one cycle, then go to IDLE.
- Arbitration happens only in IDLE. The only pending request wins. If both are pending, round-robin applies: the port not granted last time wins. last_grant updates on every grant.
- Addressing and data in XFER, for cnt = k:
  - mem_addr = latched_addr + k, truncated to ADDR_W bits. This wraps at 2^ADDR_W. Unaligned addresses are legal.
- Store: mem_we = 1 and mem_wdata = wdata[31-8k -: 8].
- Load or fetch:
  - mem_we = 0.
  - On each XFER edge, mem_rdata is shifted into an assembly register, MSB byte first.
  - On entry to ACK, the assembled word is copied to the granted port's rdata.
- Outside XFER: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Once granted, a transaction always runs to completion, even if req is dropped or the address changes. The latched values are used.
- A store acknowledges via d_ack and leaves d_rdata unchanged.
- Requests never queue internally. A non-granted requester simply stays pending.
- Reset mid-transaction: the next state is IDLE and no ack is issued. Bytes already written stay written. last_grant resets.

## Timing
- Reset values:
  - State: IDLE.
  - cnt = 0.
  - Outputs: if_ack, d_ack, busy, mem_we, mem_addr, mem_wdata all 0.
  - if_rdata = d_rdata = 0.
  - last_grant = fetch, so data wins the first tie.
- Latency: request seen in IDLE at cycle 0 → bytes on the memory port in cycles 1–4 → ack in cycle 5 → IDLE in cycle 6. Total 6 cycles per transaction. Back-to-back throughput is one word per 6 cycles.
- The requester must deassert req in the cycle after ack (cycle 6). If req is still high in IDLE, that is a new request.
- A loser's wait is exactly 6 cycles when the other port is granted in the same IDLE cycle.
- busy is high in cycles 1–5.
- The ack outputs and rdata outputs are registered. The memory-port outputs are decoded from registered state and cnt (no combinational path from req inputs).

## Test plan
- **Fetch read:** memory[4..7] = 8C,A2,00,10; if_req = 1, if_addr = 4 → mem_addr 4,5,6,7 in cycles 1–4; if_ack in cycle 5 with if_rdata = 32'h8CA20010; busy = 1 in cycles 1–5.
- **Store then load:** d_we = 1, d_addr = 8, d_wdata = 32'hDEADBEEF → memory[8..11] = DE,AD,BE,EF with mem_we = 1 for exactly 4 cycles; d_rdata unchanged. A following load of d_addr = 8 → d_rdata = 32'hDEADBEEF.
- **Simultaneous requests after reset:** d_req and if_req both rise in the same IDLE cycle → data granted first, d_ack in cycle 5; fetch granted in cycle 6, if_ack in cycle 11. A repeated tie with last_grant = data → fetch wins.
- **Wrap-around, ADDR_W = 5:** load at d_addr = 30 → mem_addr 30,31,0,1; d_rdata = {mem[30],mem[31],mem[0],mem[1]}.
- **Reset mid-store:** reset asserted at cycle 2 of a store to address 12 → only mem[12..13] written; no d_ack; all outputs 0 next cycle; state IDLE.
- **Request dropped mid-transaction:** if_req deasserted in cycle 2 → transaction completes and if_ack still pulses in cycle 5; no new grant in cycle 6.

Source files
------------

// File: rtl/byte_mem_arbiter.sv
// Shares one byte-wide memory port between instruction fetch and data load/store.
// Each 32-bit access is sequenced as four big-endian byte transfers followed by an ack cycle.
module byte_mem_arbiter #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                we_reg;
    logic [31:0]         wdata_reg;
    logic                sel_d_reg;
    logic                last_grant_reg;   // 1 = data port was granted last
    logic [31:0]         asm_reg;
    logic [31:0]         if_rdata_reg;
    logic [31:0]         d_rdata_reg;
    logic                if_ack_reg;
    logic                d_ack_reg;

    logic                grant_any;
    logic                grant_d;
    logic [31:0]         asm_next;
    logic [7:0]          wbyte [4];

    // Round-robin only matters on a tie: the port not granted last time wins.
    assign grant_any = if_req | d_req;
    assign grant_d   = d_req & (~if_req | ~last_grant_reg);
    assign asm_next  = {asm_reg[23:0], mem_rdata};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wbyte[gi] = wdata_reg[31-8*gi -: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_any) state_next = XFER;
            XFER:    if (cnt_reg == 2'd3) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_reg != IDLE);
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        if (state_reg == XFER) begin
            mem_addr = addr_reg + ADDR_W'(cnt_reg);
            mem_we   = we_reg;
            if (we_reg) begin
                mem_wdata = wbyte[cnt_reg];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= 2'd0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= 32'h0;
            sel_d_reg      <= 1'b0;
            last_grant_reg <= 1'b0;
            asm_reg        <= 32'h0;
            if_rdata_reg   <= 32'h0;
            d_rdata_reg    <= 32'h0;
            if_ack_reg     <= 1'b0;
            d_ack_reg      <= 1'b0;
        end else begin
            if_ack_reg <= 1'b0;
            d_ack_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        sel_d_reg      <= grant_d;
                        last_grant_reg <= grant_d;
                        addr_reg       <= grant_d ? d_addr : if_addr;
                        we_reg         <= grant_d & d_we;
                        wdata_reg      <= grant_d ? d_wdata : 32'h0;
                        cnt_reg        <= 2'd0;
                    end
                end
                XFER: begin
                    cnt_reg <= cnt_reg + 2'd1;
                    if (!we_reg) begin
                        asm_reg <= asm_next;
                    end
                    if (cnt_reg == 2'd3) begin
                        if (sel_d_reg) begin
                            d_ack_reg <= 1'b1;
                            if (!we_reg) begin
                                d_rdata_reg <= asm_next;
                            end
                        end else begin
                            if_ack_reg   <= 1'b1;
                            if_rdata_reg <= asm_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_ack   = if_ack_reg;
    assign d_ack    = d_ack_reg;
    assign if_rdata = if_rdata_reg;
    assign d_rdata  = d_rdata_reg;

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Scoreboard bench for byte_mem_arbiter: expected words are queued at issue time
// and compared when the matching ack appears.
module tb_byte_mem_arbiter;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;

    logic [7:0]  mem     [0:31];
    logic [7:0]  ref_mem [0:31];
    logic [31:0] if_q [$];
    logic [31:0] d_q  [$];
    logic [31:0] d_rdata_exp;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    byte_mem_arbiter #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one cycle, sample at the falling edge and retire any acks against the scoreboard.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (if_ack === 1'b1) begin
            if (if_q.size() == 0) check("if_ack_unexpected", 32'd1, 32'd0);
            else check("if_rdata", if_rdata, if_q.pop_front());
        end
        if (d_ack === 1'b1) begin
            if (d_q.size() == 0) check("d_ack_unexpected", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, d_q.pop_front());
        end
    endtask

    task automatic issue(input bit is_d, input bit we, input logic [AW-1:0] addr,
                         input logic [31:0] wdata);
        logic [31:0]   w;
        logic [AW-1:0] a;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        if (is_d && we) begin
            for (int k = 0; k < 4; k++) begin
                a = addr + AW'(k);
                ref_mem[a] = 8'(wdata >> (8 * (3 - k)));
            end
            d_q.push_back(d_rdata_exp);
        end else begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                a = addr + AW'(k);
                w = {w[23:0], ref_mem[a]};
            end
            if (is_d) begin
                d_rdata_exp = w;
                d_q.push_back(w);
            end else begin
                if_q.push_back(w);
            end
        end
    endtask

    // Follow one granted transaction from cycle 1 through the idle cycle after its ack.
    task automatic expect_txn(input bit is_d, input bit we, input logic [AW-1:0] addr,
                              input logic [31:0] wdata, input int drop_at);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("busy", 32'(busy), 32'd1);
            if (k <= 4) begin
                check("mem_addr", 32'(mem_addr), 32'(AW'(32'(addr) + k - 1)));
                check("mem_we", 32'(mem_we), 32'(we));
                if (we) check("mem_wdata", 32'(mem_wdata), 32'(8'(wdata >> (8 * (4 - k)))));
            end else begin
                check(is_d ? "d_ack" : "if_ack", 32'(is_d ? d_ack : if_ack), 32'd1);
                check(is_d ? "if_ack_idle" : "d_ack_idle", 32'(is_d ? if_ack : d_ack), 32'd0);
                check("mem_we_ack", 32'(mem_we), 32'd0);
                check("mem_addr_ack", 32'(mem_addr), 32'd0);
            end
            if (k == drop_at || k == 5) begin
                if (is_d) d_req = 1'b0;
                else if_req = 1'b0;
            end
        end
        tick();
        check("busy_idle", 32'(busy), 32'd0);
        check("mem_we_idle", 32'(mem_we), 32'd0);
        check("ack_idle", 32'({if_ack, d_ack}), 32'd0);
        $display("txn %s we=%0d addr=%0d wdata=%h completed at cycle %0d",
                 is_d ? "data" : "fetch", we, addr, wdata, cyc);
    endtask

    task automatic check_mem();
        for (int i = 0; i < 32; i++) check("mem_contents", 32'(mem[i]), 32'(ref_mem[i]));
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = 32'h0;
        d_rdata_exp = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
        mem[4] = 8'h8C; mem[5] = 8'hA2; mem[6] = 8'h00; mem[7] = 8'h10;
        for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({if_ack, d_ack}), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Tie right after reset: data first, fetch granted in cycle 6, acked in cycle 11.
        issue(1'b1, 1'b0, 5'd16, 32'h0);
        issue(1'b0, 1'b0, 5'd4, 32'h0);
        expect_txn(1'b1, 1'b0, 5'd16, 32'h0, 5);
        expect_txn(1'b0, 1'b0, 5'd4, 32'h0, 5);

        issue(1'b1, 1'b1, 5'd8, 32'hDEADBEEF);
        expect_txn(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 5);
        check_mem();

        // Tie with data granted last: fetch wins this time.
        issue(1'b1, 1'b0, 5'd8, 32'h0);
        issue(1'b0, 1'b0, 5'd20, 32'h0);
        expect_txn(1'b0, 1'b0, 5'd20, 32'h0, 5);
        expect_txn(1'b1, 1'b0, 5'd8, 32'h0, 5);

        issue(1'b1, 1'b0, 5'd30, 32'h0);
        expect_txn(1'b1, 1'b0, 5'd30, 32'h0, 5);

        issue(1'b0, 1'b0, 5'd0, 32'h0);
        expect_txn(1'b0, 1'b0, 5'd0, 32'h0, 2);
        tick();
        check("no_regrant", 32'(busy), 32'd0);

        // Reset during cycle 2 of a store: only the first two bytes land.
        d_req = 1'b1; d_we = 1'b1; d_addr = 5'd12; d_wdata = 32'h11223344;
        tick();
        check("rst_store_addr0", 32'(mem_addr), 32'd12);
        check("rst_store_we0", 32'(mem_we), 32'd1);
        tick();
        check("rst_store_addr1", 32'(mem_addr), 32'd13);
        reset = 1'b1;
        tick();
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
        ref_mem[12] = 8'h11; ref_mem[13] = 8'h22;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("midrst_acks", 32'({if_ack, d_ack}), 32'd0);
        check("midrst_d_rdata", d_rdata, 32'd0);
        check("midrst_if_rdata", if_rdata, 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_busy", 32'(busy), 32'd0);
        end
        check_mem();
        check("if_q_drained", 32'(if_q.size()), 32'd0);
        check("d_q_drained", 32'(d_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
